// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state encoding,
// instruction field constants, ALU op codes and the control-word layout.
package mc_pkg;

    // Encoding 10 is unused; states are visible on the debug port.
    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        R_EXEC    = 4'd2,
        R_WB      = 4'd3,
        MEM_ADDR  = 4'd4,
        MEM_READ  = 4'd5,
        MEM_WB    = 4'd6,
        MEM_WRITE = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        I_EXEC    = 4'd11,
        I_WB      = 4'd12
    } state_t;

    typedef enum logic [1:0] {
        CLS_ADD,
        CLS_SUB,
        CLS_FUNCT,
        CLS_IMM
    } alu_class_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_XORI  = 6'b001110;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] AOP_AND = 4'b0000;
    localparam logic [3:0] AOP_OR  = 4'b0001;
    localparam logic [3:0] AOP_ADD = 4'b0010;
    localparam logic [3:0] AOP_SUB = 4'b0110;
    localparam logic [3:0] AOP_SLT = 4'b0111;
    localparam logic [3:0] AOP_NOR = 4'b1100;
    localparam logic [3:0] AOP_XOR = 4'b1101;

    typedef struct packed {
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/alu_decoder.sv
// Maps an ALU request class plus the opcode/funct fields to the 4-bit ALU op,
// flagging encodings that have no ALU meaning.
module alu_decoder
    import mc_pkg::*;
(
    input  alu_class_t  alu_class,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    output logic [3:0]  alu_op,
    output logic        bad
);

    always_comb begin
        alu_op = AOP_AND;
        bad    = 1'b0;
        case (alu_class)
            CLS_ADD: alu_op = AOP_ADD;
            CLS_SUB: alu_op = AOP_SUB;
            CLS_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_op = AOP_ADD;
                    FN_SUB:  alu_op = AOP_SUB;
                    FN_AND:  alu_op = AOP_AND;
                    FN_OR:   alu_op = AOP_OR;
                    FN_XOR:  alu_op = AOP_XOR;
                    FN_NOR:  alu_op = AOP_NOR;
                    FN_SLT:  alu_op = AOP_SLT;
                    default: bad = 1'b1;
                endcase
            end
            CLS_IMM: begin
                case (opcode)
                    OP_ADDI: alu_op = AOP_ADD;
                    OP_ANDI: alu_op = AOP_AND;
                    OP_ORI:  alu_op = AOP_OR;
                    OP_SLTI: alu_op = AOP_SLT;
                    OP_XORI: alu_op = AOP_XOR;
                    default: bad = 1'b1;
                endcase
            end
            default: bad = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS control unit: sequences fetch/decode/execute/memory/writeback
// and issues ALU op codes and operand selects.
module mc_control
    import mc_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [3:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       illegal,
    output logic [3:0] state
);

    state_t     state_q;
    state_t     next_state;
    ctrl_t      ctl;
    ctrl_t      ctl_out;
    alu_class_t alu_class;
    logic       use_alu;
    logic [3:0] dec_op;
    logic       dec_bad;
    logic       ready;

    assign ready = MEM_WAIT_EN ? mem_ready : 1'b1;

    alu_decoder u_alu_decoder (
        .alu_class (alu_class),
        .opcode    (opcode),
        .funct     (funct),
        .alu_op    (dec_op),
        .bad       (dec_bad)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= FETCH;
        else     state_q <= next_state;
    end

    // Moore decode of the current state; only FETCH/memory strobes look at
    // mem_ready and only the branch pc_write looks at the same-cycle zero flag.
    always_comb begin
        ctl        = '0;
        next_state = state_q;
        alu_class  = CLS_ADD;
        use_alu    = 1'b0;
        case (state_q)
            FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = 2'd1;
                use_alu       = 1'b1;
                if (ready) begin
                    ctl.ir_write = 1'b1;
                    ctl.pc_write = 1'b1;
                    next_state   = DECODE;
                end
            end
            DECODE: begin
                ctl.alu_src_b = 2'd3;
                use_alu       = 1'b1;
                case (opcode)
                    OP_RTYPE:       next_state = R_EXEC;
                    OP_LW, OP_SW:   next_state = MEM_ADDR;
                    OP_BEQ, OP_BNE: next_state = BRANCH;
                    OP_J:           next_state = JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_XORI:
                                    next_state = I_EXEC;
                    default: begin
                        ctl.illegal = 1'b1;
                        next_state  = FETCH;
                    end
                endcase
            end
            R_EXEC: begin
                ctl.alu_src_a = 1'b1;
                alu_class     = CLS_FUNCT;
                use_alu       = 1'b1;
                if (dec_bad) begin
                    ctl.illegal = 1'b1;
                    next_state  = FETCH;
                end else begin
                    next_state  = R_WB;
                end
            end
            R_WB: begin
                ctl.reg_dst   = 1'b1;
                ctl.reg_write = 1'b1;
                alu_class     = CLS_FUNCT;
                use_alu       = 1'b1;
                next_state    = FETCH;
            end
            MEM_ADDR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = 2'd2;
                use_alu       = 1'b1;
                if (opcode == OP_LW)      next_state = MEM_READ;
                else if (opcode == OP_SW) next_state = MEM_WRITE;
                else                      next_state = FETCH;
            end
            MEM_READ: begin
                ctl.mem_read = 1'b1;
                ctl.i_or_d   = 1'b1;
                if (ready) next_state = MEM_WB;
            end
            MEM_WB: begin
                ctl.mem_to_reg = 1'b1;
                ctl.reg_write  = 1'b1;
                next_state     = FETCH;
            end
            MEM_WRITE: begin
                ctl.mem_write = 1'b1;
                ctl.i_or_d    = 1'b1;
                if (ready) next_state = FETCH;
            end
            BRANCH: begin
                ctl.alu_src_a = 1'b1;
                ctl.pc_src    = 2'd1;
                ctl.pc_write  = (opcode == OP_BNE) ? ~zero : zero;
                alu_class     = CLS_SUB;
                use_alu       = 1'b1;
                next_state    = FETCH;
            end
            JUMP: begin
                ctl.pc_src   = 2'd2;
                ctl.pc_write = 1'b1;
                next_state   = FETCH;
            end
            I_EXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = 2'd2;
                alu_class     = CLS_IMM;
                use_alu       = 1'b1;
                next_state    = I_WB;
            end
            I_WB: begin
                ctl.reg_write = 1'b1;
                alu_class     = CLS_IMM;
                use_alu       = 1'b1;
                next_state    = FETCH;
            end
            default: next_state = FETCH;
        endcase
    end

    // Reset forces every output low in the same cycle, abandoning any access.
    assign ctl_out    = rst ? '0 : ctl;
    assign alu_op     = (rst || !use_alu) ? AOP_AND : dec_op;
    assign state      = rst ? 4'd0 : state_q;
    assign alu_src_a  = ctl_out.alu_src_a;
    assign alu_src_b  = ctl_out.alu_src_b;
    assign pc_write   = ctl_out.pc_write;
    assign pc_src     = ctl_out.pc_src;
    assign i_or_d     = ctl_out.i_or_d;
    assign mem_read   = ctl_out.mem_read;
    assign mem_write  = ctl_out.mem_write;
    assign ir_write   = ctl_out.ir_write;
    assign mem_to_reg = ctl_out.mem_to_reg;
    assign reg_dst    = ctl_out.reg_dst;
    assign reg_write  = ctl_out.reg_write;
    assign illegal    = ctl_out.illegal;

endmodule
